sipo_frame_ctrl: RTL

Serial frame receiver controller that sequences a WIDTH-bit serial-in/parallel-out shift register. It detects a start bit, shifts in exactly WIDTH data bits, checks an optional even-parity bit and the stop bit, and presents the completed word on a valid/ready output port. It sits between a bit-strobed serial line and any parallel consumer, and turns the free-running SIPO datapath into a framed, flow-controlled receive channel.

---
 rtl/sipo_pkg.sv | 18 +
 rtl/sipo_shift_reg.sv | 23 ++
 rtl/sipo_frame_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the framed serial receiver.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Even parity: returns 1 when data bits plus the parity bit hold an odd number of ones.
  function automatic logic parity_check(input logic [31:0] data, input logic pbit);
    return (^data) ^ pbit;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Left-shifting serial-in/parallel-out register; the first bit in ends up as the MSB.
module sipo_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], serial_in};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: start bit, WIDTH data bits, optional even parity, stop bit,
// with the completed word held on a valid/ready port.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit (0)
// DATA   | shifting in WIDTH data bits
// PARITY | latching the even-parity bit
// STOP   | sampling the stop bit, then delivering or discarding the word
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_en,
  input  logic             data_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             pbit;
  logic [WIDTH-1:0] shift;

  logic start_seen;
  logic stop_edge;
  logic hold_free;
  logic load;
  logic consume;
  logic perr;

  assign start_seen = bit_en && (state == IDLE) && (serial_in != IDLE_LEVEL);
  assign stop_edge  = bit_en && (state == STOP);
  // The holding register can take a new word if it is empty or being drained this edge.
  assign hold_free  = !data_valid || data_ready;
  assign load       = stop_edge && (serial_in == IDLE_LEVEL) && hold_free;
  assign consume    = data_valid && data_ready;
  assign perr       = (PARITY_EN != 0) ? parity_check(32'(shift), pbit) : 1'b0;
  assign busy       = (state != IDLE);

  sipo_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_seen),
    .shift_en  (bit_en && (state == DATA)),
    .serial_in (serial_in),
    .q         (shift)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pbit  <= 1'b0;
    end else if (bit_en) begin
      case (state)
        IDLE: begin
          if (serial_in != IDLE_LEVEL) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          pbit  <= serial_in;
          state <= STOP;
        end
        STOP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
    end else if (load) begin
      data_out   <= shift;
      data_valid <= 1'b1;
      parity_err <= perr;
    end else if (consume) begin
      data_valid <= 1'b0;
    end
  end

  // Sticky flags: a set on the same edge as err_clr takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (stop_edge && (serial_in != IDLE_LEVEL)) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
      if (stop_edge && (serial_in == IDLE_LEVEL) && !hold_free) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
